// File: rtl/rr_pkg.sv
// Shared sizing and types for the arbiter, pop mux and egress stages.
// Pure definitions: no latency and no flow control of its own.
package rr_pkg;
  localparam int QUEUE_QUANTITY = 4;
  localparam int DATA_BITS      = 8;
  localparam int SEL_W          = $clog2(QUEUE_QUANTITY);
  localparam int OUT_DEPTH      = 2;
  localparam int BUS_W          = QUEUE_QUANTITY * DATA_BITS;

  typedef struct packed {
    logic [SEL_W-1:0]     src;
    logic [DATA_BITS-1:0] dat;
  } entry_t;

  // FIFO n sits at bus[(n+1)*DATA_BITS-1 : n*DATA_BITS].
  function automatic logic [DATA_BITS-1:0] fifo_slice(input logic [BUS_W-1:0] bus,
                                                      input logic [SEL_W-1:0] idx);
    return bus[int'(idx)*DATA_BITS +: DATA_BITS];
  endfunction
endpackage

// File: rtl/rr_out_buffer.sv
// Two-entry in-order {src,data} buffer; a write is visible at the head one cycle later.
// Head register drives the output directly; rd_dat holds while rd_vld && !rd_rdy.
module rr_out_buffer
  import rr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_vld,
  input  entry_t     wr_dat,
  output logic       rd_vld,
  input  logic       rd_rdy,
  output entry_t     rd_dat,
  output logic [1:0] count
);
  entry_t     head;
  entry_t     tail;
  logic [1:0] cnt;
  logic       xfer;

  assign rd_vld = (cnt != 2'd0);
  assign rd_dat = head;
  assign count  = cnt;
  assign xfer   = rd_vld && rd_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= 2'd0;
    end else begin
      case ({wr_vld, xfer})
        2'b10: begin
          if (cnt == 2'd0) head <= wr_dat;
          else             tail <= wr_dat;
          if (cnt != 2'(OUT_DEPTH)) cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: the new word lands behind whatever remains.
          if (cnt == 2'd1) begin
            head <= wr_dat;
          end else begin
            head <= tail;
            tail <= wr_dat;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/rr_pop_mux.sv
// Turns arbiter grants into one-hot FIFO pops and buffers the returned words; pop->valid_out is 2 cycles.
// Pops are issued only with a free buffer slot reserved, so downstream stalls never drop or underflow.
module rr_pop_mux
  import rr_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enb,
  input  logic [SEL_W-1:0]          selector,
  input  logic                      selector_enb,
  input  logic [QUEUE_QUANTITY-1:0] buf_empty,
  input  logic [BUS_W-1:0]          fifo_data,
  output logic [QUEUE_QUANTITY-1:0] pop,
  output logic [DATA_BITS-1:0]      data_out,
  output logic [SEL_W-1:0]          src_out,
  output logic                      valid_out,
  input  logic                      ready_in,
  output logic                      busy
);
  logic             inflight;
  logic [SEL_W-1:0] sel_d;
  logic [1:0]       count;
  logic             xfer;
  logic [2:0]       occ;
  logic             credit;
  logic             issue;
  entry_t           cap;
  entry_t           head;

  assign xfer = valid_out && ready_in;
  assign occ  = {1'b0, count} + {2'b00, inflight};
  // A word leaving this cycle frees its slot for the pop issued now.
  assign credit = occ < (3'd2 + {2'b00, xfer});
  assign issue  = !rst && enb && selector_enb && !buf_empty[selector] && credit;
  assign pop    = issue ? (QUEUE_QUANTITY'(1) << selector) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      sel_d    <= '0;
    end else begin
      inflight <= issue;
      if (issue) sel_d <= selector;
    end
  end

  assign cap.src = sel_d;
  assign cap.dat = fifo_slice(fifo_data, sel_d);

  rr_out_buffer u_out_buffer (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (inflight),
    .wr_dat (cap),
    .rd_vld (valid_out),
    .rd_rdy (ready_in),
    .rd_dat (head),
    .count  (count)
  );

  assign data_out = head.dat;
  assign src_out  = head.src;
  assign busy     = inflight || (count != 2'd0);
endmodule

// File: tb/tb_rr_pop_mux.sv
// Directed bench for rr_pop_mux with a behavioural one-cycle-latency FIFO model per queue.
module tb_rr_pop_mux;
  import rr_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      enb;
  logic [SEL_W-1:0]          selector;
  logic                      selector_enb;
  logic [QUEUE_QUANTITY-1:0] buf_empty;
  logic [BUS_W-1:0]          fifo_data;
  logic [QUEUE_QUANTITY-1:0] pop;
  logic [DATA_BITS-1:0]      data_out;
  logic [SEL_W-1:0]          src_out;
  logic                      valid_out;
  logic                      ready_in;
  logic                      busy;

  always #5 clk = ~clk;

  rr_pop_mux dut (
    .clk          (clk),
    .rst          (rst),
    .enb          (enb),
    .selector     (selector),
    .selector_enb (selector_enb),
    .buf_empty    (buf_empty),
    .fifo_data    (fifo_data),
    .pop          (pop),
    .data_out     (data_out),
    .src_out      (src_out),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .busy         (busy)
  );

  // FIFO model: popped word appears on the read port the cycle after pop.
  logic [DATA_BITS-1:0] fq [QUEUE_QUANTITY][$];
  logic [DATA_BITS-1:0] rd [QUEUE_QUANTITY];
  int uflow = 0;

  always @(posedge clk) begin
    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      if (pop[i]) begin
        if (fq[i].size() != 0) rd[i] <= fq[i].pop_front();
        else                   uflow++;
      end
    end
  end

  for (genvar g = 0; g < QUEUE_QUANTITY; g++) begin : g_rd
    assign fifo_data[g*DATA_BITS +: DATA_BITS] = rd[g];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input logic r, input logic e, input logic se, input logic rdy,
                       input logic [SEL_W-1:0] s);
    rst          = r;
    enb          = e;
    selector_enb = se;
    ready_in     = rdy;
    selector     = s;
    for (int i = 0; i < QUEUE_QUANTITY; i++) buf_empty[i] = (fq[i].size() == 0);
    #1;
  endtask

  typedef struct {
    logic                      r, e, se, rdy;
    logic [SEL_W-1:0]          sel;
    logic [QUEUE_QUANTITY-1:0] pop;
    logic                      vld;
    logic [DATA_BITS-1:0]      dat;
    logic [SEL_W-1:0]          src;
    logic                      busy;
  } vec_t;

  vec_t tbl [16];
  logic [DATA_BITS-1:0] expq [3];
  int   npop;
  int   got;
  logic seen;

  initial begin
    rst = 1'b1; enb = 1'b0; selector = '0; selector_enb = 1'b0; ready_in = 1'b0;
    buf_empty = '1;

    fq[0].push_back(8'hA0);
    fq[1].push_back(8'hB1);
    fq[3].push_back(8'hD3);
    fq[2].push_back(8'h11);
    fq[2].push_back(8'h22);
    fq[2].push_back(8'h33);

    //           r  e  se rdy sel   pop   vld dat    src   busy
    tbl[0]  = '{1, 1, 1, 1, 2'd2, 4'h0, 0, 8'h00, 2'd0, 0};
    tbl[1]  = '{0, 1, 0, 1, 2'd2, 4'h0, 0, 8'h00, 2'd0, 0};
    tbl[2]  = '{0, 0, 1, 1, 2'd2, 4'h0, 0, 8'h00, 2'd0, 0};
    tbl[3]  = '{0, 1, 1, 1, 2'd0, 4'h1, 0, 8'h00, 2'd0, 0};
    tbl[4]  = '{0, 1, 1, 1, 2'd1, 4'h2, 0, 8'h00, 2'd0, 1};
    tbl[5]  = '{0, 1, 1, 1, 2'd3, 4'h8, 1, 8'hA0, 2'd0, 1};
    tbl[6]  = '{0, 1, 0, 1, 2'd3, 4'h0, 1, 8'hB1, 2'd1, 1};
    tbl[7]  = '{0, 1, 0, 1, 2'd3, 4'h0, 1, 8'hD3, 2'd3, 1};
    tbl[8]  = '{0, 1, 0, 1, 2'd3, 4'h0, 0, 8'h00, 2'd0, 0};
    tbl[9]  = '{0, 1, 1, 1, 2'd3, 4'h0, 0, 8'h00, 2'd0, 0};
    tbl[10] = '{0, 1, 1, 1, 2'd2, 4'h4, 0, 8'h00, 2'd0, 0};
    tbl[11] = '{0, 1, 1, 1, 2'd2, 4'h4, 0, 8'h00, 2'd0, 1};
    tbl[12] = '{0, 1, 1, 1, 2'd2, 4'h4, 1, 8'h11, 2'd2, 1};
    tbl[13] = '{0, 1, 1, 1, 2'd2, 4'h0, 1, 8'h22, 2'd2, 1};
    tbl[14] = '{0, 1, 1, 1, 2'd2, 4'h0, 1, 8'h33, 2'd2, 1};
    tbl[15] = '{0, 1, 1, 1, 2'd2, 4'h0, 0, 8'h00, 2'd0, 0};

    @(negedge clk);
    apply(1, 0, 0, 0, 2'd0);
    @(negedge clk);
    apply(1, 0, 0, 0, 2'd0);
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].r, tbl[i].e, tbl[i].se, tbl[i].rdy, tbl[i].sel);
      chk($sformatf("tbl%0d_pop", i),  32'(pop),       32'(tbl[i].pop));
      chk($sformatf("tbl%0d_vld", i),  32'(valid_out), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_busy", i), 32'(busy),      32'(tbl[i].busy));
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_dat", i), 32'(data_out), 32'(tbl[i].dat));
        chk($sformatf("tbl%0d_src", i), 32'(src_out),  32'(tbl[i].src));
      end
      @(negedge clk);
    end

    // Backpressure: only two pops fit, head holds while stalled.
    fq[2].push_back(8'h11);
    fq[2].push_back(8'h22);
    fq[2].push_back(8'h33);
    npop = 0;
    for (int c = 0; c < 5; c++) begin
      apply(0, 1, 1, 0, 2'd2);
      if (pop[2]) npop++;
      if (c >= 2) begin
        chk("bp_hold_vld", 32'(valid_out), 32'd1);
        chk("bp_hold_dat", 32'(data_out), 32'h11);
      end
      @(negedge clk);
    end
    chk("bp_pops", 32'(npop), 32'd2);
    expq[0] = 8'h11; expq[1] = 8'h22; expq[2] = 8'h33;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      apply(0, 1, 1, 1, 2'd2);
      if (valid_out) begin
        if (got < 3) chk($sformatf("bp_order%0d", got), 32'(data_out), 32'(expq[got]));
        chk("bp_src", 32'(src_out), 32'd2);
        got++;
      end
      @(negedge clk);
    end
    chk("bp_count", 32'(got), 32'd3);

    // Reset while a popped word is in flight.
    fq[1].push_back(8'h5A);
    apply(0, 1, 1, 1, 2'd1);
    chk("rst_first_pop", 32'(pop), 32'h2);
    @(negedge clk);
    apply(1, 1, 1, 1, 2'd1);
    chk("rst_pop_low", 32'(pop), 32'h0);
    @(negedge clk);
    apply(0, 1, 0, 1, 2'd1);
    chk("rst_vld", 32'(valid_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      apply(0, 1, 0, 1, 2'd1);
      if (valid_out) seen = 1'b1;
    end
    chk("rst_no_deliver", 32'(seen), 32'd0);
    @(negedge clk);

    // enb drops right after a pop: capture still completes.
    fq[0].push_back(8'h3C);
    fq[0].push_back(8'h4D);
    apply(0, 1, 1, 1, 2'd0);
    chk("enb_pop", 32'(pop), 32'h1);
    @(negedge clk);
    apply(0, 0, 1, 1, 2'd0);
    chk("enb_off_pop", 32'(pop), 32'h0);
    chk("enb_off_busy", 32'(busy), 32'd1);
    @(negedge clk);
    apply(0, 0, 1, 1, 2'd0);
    chk("enb_off_pop2", 32'(pop), 32'h0);
    chk("enb_vld", 32'(valid_out), 32'd1);
    chk("enb_dat", 32'(data_out), 32'h3C);
    chk("enb_src", 32'(src_out), 32'd0);
    @(negedge clk);
    apply(0, 0, 1, 1, 2'd0);
    chk("enb_off_pop3", 32'(pop), 32'h0);
    chk("enb_done_vld", 32'(valid_out), 32'd0);
    chk("enb_done_busy", 32'(busy), 32'd0);

    chk("underflow", 32'(uflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_pop_mux.md
Name: rr_pop_mux

Overview:
Downstream consumer of the weighted round-robin arbiter. Turns the arbiter's selector/selector_enb into a one-hot pop to the selected FIFO and captures that FIFO's read data one cycle later. Data goes into a 2-entry output buffer that presents a valid/ready stream to the next stage (egress/serializer). The block guarantees no FIFO underflow and no loss of popped words under downstream backpressure.

Parameters:
QUEUE_QUANTITY, 4, number of FIFOs / arbiter inputs
DATA_BITS, 8, width of one FIFO word
OUT_DEPTH, 2, output buffer entries (fixed at 2; the credit logic depends on it)

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  synchronous, active-high reset
enb  input  1  global enable; gates issuing of new pops only
selector  input  $clog2(QUEUE_QUANTITY)  FIFO chosen by the arbiter
selector_enb  input  1  selector is valid this cycle
buf_empty  input  QUEUE_QUANTITY  per-FIFO empty flags
fifo_data  input  QUEUE_QUANTITY*DATA_BITS  concatenated FIFO read ports; FIFO n occupies [(n+1)*DATA_BITS-1 : n*DATA_BITS]
pop  output  QUEUE_QUANTITY  one-hot read strobe to the FIFOs (combinational)
data_out  output  DATA_BITS  head-of-buffer word
src_out  output  $clog2(QUEUE_QUANTITY)  index of the FIFO data_out came from
valid_out  output  1  data_out/src_out valid
ready_in  input  1  downstream accepts the word this cycle
busy  output  1  pop in flight or buffer non-empty

Behaviour:
- FIFO read model: pop[i] high in cycle t, so fifo_data slice i holds the popped word during cycle t+1.
- Credit rule: issue = enb && selector_enb && !buf_empty[selector] && (count + inflight - (valid_out && ready_in)) < 2. Here count is buffer occupancy (0..2) and inflight is 1 bit.
- pop = issue ? (1 << selector) : 0. This is combinational, so there is a same-cycle path from ready_in to pop.
- On an issue edge: inflight<=1, sel_d<=selector.
- Cycle after issue: the fifo_data slice sel_d is written to buffer tail with src=sel_d, and inflight clears unless a new issue happens in the same cycle.
- Latency: pop at cycle t gives valid_out at cycle t+2. With ready_in held high and a non-empty selected FIFO, throughput is one word per cycle, no bubbles.
- Buffer: FIFO order, 2 entries. data_out, src_out and valid_out are driven from the head register. A transfer occurs when valid_out && ready_in.
- Stall: while valid_out && !ready_in, data_out and src_out stay stable.
- Simultaneous capture and transfer with count==2 cannot occur; the credit rule prevents it. Capture and transfer in the same cycle leave count unchanged.
- enb=0: no new pops. An in-flight capture still completes and the output handshake keeps running. Data is never dropped.
- selector_enb=0 or buf_empty[selector]=1: pop=0, no state change from the issue path.
- Reset (including mid-operation): pop=0 combinationally while rst is high; count=0, inflight=0, valid_out=0, data_out=0, src_out=0, busy=0. An in-flight word is discarded.
- busy = inflight || (count != 0).
- Index arithmetic is modulo QUEUE_QUANTITY. Width of count is 2 bits.

Decomposition:
- Shared package `rr_pkg`: QUEUE_QUANTITY, DATA_BITS, SEL_W=$clog2(QUEUE_QUANTITY), OUT_DEPTH, and a slice helper/constant for fifo_data indexing. The arbiter and egress stage use the same package.
- One sub-module: `rr_out_buffer`, a 2-entry valid/ready FIFO carrying {src, data} with count output.
- Pop/credit logic and capture stay in the top.

Test Plan:
- Reset mid-stream: pop FIFO 1 at cycle t, assert rst at t+1. Required: valid_out=0 and busy=0 after the edge, the word is not delivered, and pop=0 during rst.
- Steady stream: FIFO 2 holds 0x11,0x22,0x33, selector=2, ready_in=1. Required: pop[2] high 3 consecutive cycles, and data_out=0x11,0x22,0x33 with src_out=2 on consecutive cycles starting 2 cycles after the first pop.
- Backpressure: same stimulus with ready_in=0. Required: exactly 2 pops, then pop=0, data_out held at 0x11. When ready_in is raised, all 3 words arrive in order with no loss or duplication.
- Empty guard: selector=3, selector_enb=1, buf_empty[3]=1. Required: pop=0 and busy stays 0. Also selector_enb=0 with a non-empty FIFO gives pop=0.
- enb drop: pop at cycle t, enb=0 from t+1. Required: the word is still captured and delivered, and no further pops while enb=0.
- Interleaved sources: selector sequence 0,1,3 with data 0xA0,0xB1,0xD3. Required: output order 0xA0/src 0, 0xB1/src 1, 0xD3/src 3.
